rob_commit_ctrl: RTL and testbench

- Reorder-buffer commit scheduler sitting between Decoder/execution units and the register file.
- Allocates in-order ROB slots at issue and collects out-of-order writebacks.
- Retires at most one instruction per cycle in program order, driving the register-file commit port (commit, rd, val, rob_pos).
- On a mispredicted branch reaching the head, sequences a one-cycle rollback that flushes the buffer and clears register renaming.

---
 rtl/rob_commit_ctrl.sv | 166 ++++++++++++++++
 tb/tb_rob_commit_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit_ctrl.sv
// Reorder-buffer commit scheduler: in-order allocation, out-of-order writeback,
// one in-order retirement per cycle and a one-cycle rollback on a mispredicted head.
module rob_commit_ctrl #(
    parameter int unsigned ROB_SIZE = 16,
    parameter int unsigned POS_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rd,
    output logic [POS_W-1:0] issue_rob_pos,
    output logic             rob_full,
    input  logic             wb_valid,
    input  logic [POS_W-1:0] wb_rob_pos,
    input  logic [31:0]      wb_val,
    input  logic             wb_mispredict,
    output logic             commit,
    output logic [4:0]       commit_rd,
    output logic [31:0]      commit_val,
    output logic [POS_W-1:0] commit_rob_pos,
    output logic             rollback
);

    typedef enum logic {StRun, StFlush} state_e;

    localparam logic [POS_W:0] FullCnt = (POS_W+1)'(ROB_SIZE);

    state_e              state_q, state_d;
    logic [POS_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic [POS_W:0]      count_q, count_d;
    logic [ROB_SIZE-1:0] busy_q, busy_d, ready_q, ready_d, misp_q, misp_d;
    logic [4:0]          rd_q  [ROB_SIZE];
    logic [4:0]          rd_d  [ROB_SIZE];
    logic [31:0]         val_q [ROB_SIZE];
    logic [31:0]         val_d [ROB_SIZE];

    logic                commit_q, commit_d, rollback_q, rollback_d;
    logic [4:0]          commit_rd_q, commit_rd_d;
    logic [31:0]         commit_val_q, commit_val_d;
    logic [POS_W-1:0]    commit_pos_q, commit_pos_d;

    logic                do_issue, do_commit;

    assign rob_full       = (count_q == FullCnt) || (state_q == StFlush);
    assign issue_rob_pos  = tail_q;
    assign commit         = commit_q;
    assign commit_rd      = commit_rd_q;
    assign commit_val     = commit_val_q;
    assign commit_rob_pos = commit_pos_q;
    assign rollback       = rollback_q;

    always_comb begin
        state_d      = state_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        busy_d       = busy_q;
        ready_d      = ready_q;
        misp_d       = misp_q;
        rd_d         = rd_q;
        val_d        = val_q;
        commit_d     = 1'b0;
        rollback_d   = 1'b0;
        commit_rd_d  = commit_rd_q;
        commit_val_d = commit_val_q;
        commit_pos_d = commit_pos_q;
        do_issue     = 1'b0;
        do_commit    = 1'b0;

        if (rdy) begin
            unique case (state_q)
                StRun: begin
                    do_issue  = issue_valid && !rob_full;
                    do_commit = busy_q[head_q] && ready_q[head_q];

                    if (wb_valid && busy_q[wb_rob_pos]) begin
                        ready_d[wb_rob_pos] = 1'b1;
                        val_d[wb_rob_pos]   = wb_val;
                        misp_d[wb_rob_pos]  = wb_mispredict;
                    end

                    // The issue slot is never busy unless full, so it cannot
                    // collide with the writeback or the committing head.
                    if (do_issue) begin
                        busy_d[tail_q]  = 1'b1;
                        ready_d[tail_q] = 1'b0;
                        misp_d[tail_q]  = 1'b0;
                        rd_d[tail_q]    = issue_rd;
                        tail_d          = tail_q + POS_W'(1);
                    end

                    if (do_commit) begin
                        commit_d        = 1'b1;
                        commit_rd_d     = rd_q[head_q];
                        commit_val_d    = val_q[head_q];
                        commit_pos_d    = head_q;
                        busy_d[head_q]  = 1'b0;
                        ready_d[head_q] = 1'b0;
                        misp_d[head_q]  = 1'b0;
                        rd_d[head_q]    = '0;
                        val_d[head_q]   = '0;
                        head_d          = head_q + POS_W'(1);
                        if (misp_q[head_q]) begin
                            state_d    = StFlush;
                            rollback_d = 1'b1;
                        end
                    end

                    count_d = count_q + (POS_W+1)'(do_issue) - (POS_W+1)'(do_commit);
                end
                StFlush: begin
                    busy_d  = '0;
                    ready_d = '0;
                    misp_d  = '0;
                    for (int i = 0; i < ROB_SIZE; i++) begin
                        rd_d[i]  = '0;
                        val_d[i] = '0;
                    end
                    head_d  = '0;
                    tail_d  = '0;
                    count_d = '0;
                    state_d = StRun;
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StRun;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            busy_q       <= '0;
            ready_q      <= '0;
            misp_q       <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                rd_q[i]  <= '0;
                val_q[i] <= '0;
            end
            commit_q     <= 1'b0;
            rollback_q   <= 1'b0;
            commit_rd_q  <= '0;
            commit_val_q <= '0;
            commit_pos_q <= '0;
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            busy_q       <= busy_d;
            ready_q      <= ready_d;
            misp_q       <= misp_d;
            rd_q         <= rd_d;
            val_q        <= val_d;
            commit_q     <= commit_d;
            rollback_q   <= rollback_d;
            commit_rd_q  <= commit_rd_d;
            commit_val_q <= commit_val_d;
            commit_pos_q <= commit_pos_d;
        end
    end

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Bench for rob_commit_ctrl: directed scenarios plus random traffic, checked against
// a program-order queue model of the reorder buffer.
module tb_rob_commit_ctrl;

    localparam int unsigned ROB_SIZE = 16;
    localparam int unsigned POS_W    = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             rdy = 1'b0;
    logic             issue_valid = 1'b0;
    logic [4:0]       issue_rd = '0;
    logic [POS_W-1:0] issue_rob_pos;
    logic             rob_full;
    logic             wb_valid = 1'b0;
    logic [POS_W-1:0] wb_rob_pos = '0;
    logic [31:0]      wb_val = '0;
    logic             wb_mispredict = 1'b0;
    logic             commit;
    logic [4:0]       commit_rd;
    logic [31:0]      commit_val;
    logic [POS_W-1:0] commit_rob_pos;
    logic             rollback;

    rob_commit_ctrl #(.ROB_SIZE(ROB_SIZE), .POS_W(POS_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .issue_valid    (issue_valid),
        .issue_rd       (issue_rd),
        .issue_rob_pos  (issue_rob_pos),
        .rob_full       (rob_full),
        .wb_valid       (wb_valid),
        .wb_rob_pos     (wb_rob_pos),
        .wb_val         (wb_val),
        .wb_mispredict  (wb_mispredict),
        .commit         (commit),
        .commit_rd      (commit_rd),
        .commit_val     (commit_val),
        .commit_rob_pos (commit_rob_pos),
        .rollback       (rollback)
    );

    always #5 clk = ~clk;

    // Reference model: in-flight instructions in program order.
    typedef struct {
        int          pos;
        logic [4:0]  rd;
        bit          ready;
        logic [31:0] val;
        bit          misp;
    } ent_t;

    ent_t        mq[$];
    int          m_tail;
    bit          m_flush;
    bit          e_commit, e_rollback;
    logic [4:0]  e_rd;
    logic [31:0] e_val;
    int          e_pos;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        mq.delete();
        m_tail = 0; m_flush = 0;
        e_commit = 0; e_rollback = 0; e_rd = '0; e_val = '0; e_pos = 0;
    endtask

    task automatic model_step();
        bit full;
        if (!rdy) begin
            e_commit = 0; e_rollback = 0;
            return;
        end
        if (m_flush) begin
            mq.delete();
            m_tail = 0; m_flush = 0; e_commit = 0; e_rollback = 0;
            return;
        end
        full = (mq.size() == ROB_SIZE);
        e_commit = 0; e_rollback = 0;
        if (mq.size() > 0 && mq[0].ready) begin
            e_commit = 1; e_rd = mq[0].rd; e_val = mq[0].val; e_pos = mq[0].pos;
            if (mq[0].misp) begin
                m_flush = 1; e_rollback = 1;
            end
        end
        if (wb_valid) begin
            foreach (mq[i]) begin
                if (mq[i].pos == int'(wb_rob_pos)) begin
                    mq[i].ready = 1; mq[i].val = wb_val; mq[i].misp = wb_mispredict;
                end
            end
        end
        if (e_commit) void'(mq.pop_front());
        if (issue_valid && !full) begin
            mq.push_back('{pos: m_tail, rd: issue_rd, ready: 0, val: '0, misp: 0});
            m_tail = (m_tail + 1) % ROB_SIZE;
        end
    endtask

    task automatic check_outputs();
        check("commit",   32'(commit),         32'(e_commit));
        check("rollback", 32'(rollback),       32'(e_rollback));
        check("c_rd",     32'(commit_rd),      32'(e_rd));
        check("c_val",    commit_val,          e_val);
        check("c_pos",    32'(commit_rob_pos), 32'(e_pos));
        check("full",     32'(rob_full),       32'(mq.size() == ROB_SIZE || m_flush));
        check("tail",     32'(issue_rob_pos),  32'(m_tail));
    endtask

    // One clock: inputs driven at the falling edge, outputs checked 1 after the rising edge.
    task automatic cycle(input bit r, input bit iv, input logic [4:0] ird, input bit wv,
                         input int wp, input logic [31:0] wval, input bit wm);
        rdy = r; issue_valid = iv; issue_rd = ird;
        wb_valid = wv; wb_rob_pos = POS_W'(wp); wb_val = wval; wb_mispredict = wm;
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 5'd0, 0, 0, 32'd0, 0);
    endtask

    task automatic issue(input logic [4:0] rd);
        cycle(1, 1, rd, 0, 0, 32'd0, 0);
    endtask

    task automatic wb(input int pos, input logic [31:0] val, input bit m);
        cycle(1, 0, 5'd0, 1, pos, val, m);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_outputs();
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // Asynchronous reset mid-run.
        issue(5'd3); issue(5'd4); issue(5'd8);
        wb(0, 32'h55, 0);
        #2;
        rst = 1'b0;
        #1;
        check("arst_full", 32'(rob_full), 32'd0);
        check("arst_tail", 32'(issue_rob_pos), 32'd0);
        check("arst_commit", 32'(commit), 32'd0);
        check("arst_rollback", 32'(rollback), 32'd0);
        do_reset();

        // In-order retire despite out-of-order writeback.
        issue(5'd5); issue(5'd6); issue(5'd7);
        wb(2, 32'h33, 0); wb(0, 32'h11, 0); wb(1, 32'h22, 0);
        idle(4);

        // Full, dropped 17th issue, then wrap into pos0.
        do_reset();
        for (int i = 0; i < 16; i++) issue(5'(i + 1));
        check("full16", 32'(rob_full), 32'd1);
        issue(5'd31);
        wb(0, 32'hA0, 0);
        idle(2);
        issue(5'd30);
        check("wrap_full", 32'(rob_full), 32'd1);

        // Mispredicted branch at head.
        do_reset();
        issue(5'd1); issue(5'd2);
        wb(1, 32'h99, 0);
        wb(0, 32'h80, 1);
        idle(1);
        check("mp_commit", 32'(commit), 32'd1);
        check("mp_rb", 32'(rollback), 32'd1);
        check("mp_val", commit_val, 32'h80);
        idle(1);
        check("mp_after_full", 32'(rob_full), 32'd0);
        check("mp_after_commit", 32'(commit), 32'd0);
        idle(2);

        // rdy stall with a ready head.
        do_reset();
        issue(5'd9);
        wb(0, 32'h1234, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 5'd10, 1, 0, 32'hBAD, 0);
        idle(2);

        // Stray writeback to an empty slot, then that slot is issued fresh.
        do_reset();
        wb(9, 32'hDEAD, 0);
        for (int i = 0; i < 10; i++) issue(5'(i + 2));
        for (int i = 0; i < 9; i++) wb(i, 32'(i + 32'h100), 0);
        idle(4);
        check("stray_tail", 32'(issue_rob_pos), 32'd10);

        // Random traffic with varying issue/writeback pressure.
        do_reset();
        for (int phase = 0; phase < 6; phase++) begin
            for (int c = 0; c < 500; c++) begin
                bit          r, iv, wv, wm;
                int          wp;
                logic [31:0] wval;
                r    = ($urandom % 10) != 0;
                iv   = ($urandom % 4) < ((phase % 2 == 0) ? 3 : 1);
                wv   = ($urandom % 4) < ((phase % 2 == 0) ? 1 : 3);
                wm   = ($urandom % 20) == 0;
                wval = $urandom;
                if (mq.size() > 0 && ($urandom % 4) != 0)
                    wp = mq[$urandom_range(0, mq.size() - 1)].pos;
                else
                    wp = $urandom % ROB_SIZE;
                cycle(r, iv, 5'($urandom), wv, wp, wval, wm);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
